ex_mem_stage: RTL

//  - EX->MEM pipeline stage of the 64-bit LEGv8 datapath.
//  - Sits directly downstream of the ALU, which contains the bitwise AND/OR/XOR units, adder and shifter.
//  - Registers the ALU result, store data, destination register and memory/writeback controls.
//  - Derives the N/Z/C/V flags and holds the architectural flag register, plus a same-cycle flag bypass for B.cond.
//  - Provides a forwarding port to the hazard unit and a saturating stall-cycle counter.

---
 rtl/ex_mem_stage_pkg.sv | 22 ++
 rtl/ex_mem_stage_zero_detect.sv | 14 +
 rtl/ex_mem_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage.
package ex_mem_pkg;

  // Architectural condition flags, MSB first: {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Memory / writeback controls carried into MEM
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } mem_ctrl_t;

  // X31 as a destination is the zero register; writes to it are discarded
  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/ex_mem_stage_zero_detect.sv
// Wide NOR reduction used to produce the Z flag from the ALU result.
module zero_detect_64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] data,
  output logic         zero
);

  // Z is set only when every result bit is clear
  always_comb begin
    zero = ~|data;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register for the 64-bit LEGv8 datapath, with flag
// register, same-cycle flag bypass for B.cond and a stall-cycle counter.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DW   = 64,
  parameter int RW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic [DW-1:0]   ex_alu_result,
  input  logic            ex_alu_carry,
  input  logic            ex_alu_overflow,
  input  logic [DW-1:0]   ex_store_data,
  input  logic [RW-1:0]   ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_reg_write,
  input  logic            ex_set_flags,
  input  logic            stall,
  input  logic            flush,
  output logic            mem_valid,
  output logic [DW-1:0]   mem_alu_result,
  output logic [DW-1:0]   mem_store_data,
  output logic [RW-1:0]   mem_rd,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_reg_write,
  output logic [3:0]      flags,
  output logic [3:0]      flags_bypass,
  output logic            fwd_en,
  output logic [CNTW-1:0] stall_count
);

  logic      load;
  logic      flag_wr;
  logic      res_zero;
  flags_t    flags_new;
  flags_t    flags_q;
  mem_ctrl_t ctrl_in;
  mem_ctrl_t ctrl_q;

  zero_detect_64 #(.W(DW)) u_zero (
    .data (ex_alu_result),
    .zero (res_zero)
  );

  // Edge qualifiers, flag generation and the controls presented to the stage
  always_comb begin
    load      = ~flush & ~stall;
    flag_wr   = load & ex_valid & ex_set_flags;
    flags_new = '{n: ex_alu_result[DW-1], z: res_zero,
                  c: ex_alu_carry, v: ex_alu_overflow};
    ctrl_in   = '0;
    if (ex_valid) begin
      ctrl_in.mem_read  = ex_mem_read;
      ctrl_in.mem_write = ex_mem_write;
      // Writes to XZR are dropped here so the hazard unit never forwards them
      ctrl_in.reg_write = ex_reg_write & (ex_rd != RW'(XZR));
    end
  end

  // Stage register: flush bubbles the controls but leaves data in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid      <= 1'b0;
      ctrl_q         <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      ctrl_q    <= '0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      ctrl_q         <= ctrl_in;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
    end
  end

  // Architectural flag register, written only by a flag-setting load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (flag_wr) begin
      flags_q <= flags_new;
    end
  end

  // Saturating count of cycles the stage actually held (flush does not count)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && !flush && (stall_count != {CNTW{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Output decode: controls, forwarding enable and B.cond flag view
  always_comb begin
    mem_mem_read  = ctrl_q.mem_read;
    mem_mem_write = ctrl_q.mem_write;
    mem_reg_write = ctrl_q.reg_write;
    fwd_en        = mem_valid & ctrl_q.reg_write;
    flags         = flags_q;
    flags_bypass  = flag_wr ? flags_new : flags_q;
  end

endmodule
